pc_fetch_ctrl: RTL



---
 rtl/pc_fetch_ctrl_pkg.sv | 41 ++++
 rtl/pc_fetch_ctrl_watchdog.sv | 53 +++++
 rtl/pc_fetch_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg
// Shared types and constants for the PC / instruction-fetch sequencer.
//   branch_kind_t : encoding of the branch_kind input
//   state_t       : sequencer states
//   TIMEOUT_DEFAULT : default imem wait limit for the optional watchdog
//   is_redirect() : decides whether a resolved branch changes the PC
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BR_REL = 2'b00,   // PC-relative branch, only redirects when taken
        BR_ABS = 2'b01,   // absolute jump
        BR_REG = 2'b10    // register-indirect jump (target = RS1_val)
    } branch_kind_t;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        DRAIN = 2'b11
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;

    // Encoding 2'b11 is reserved and never redirects, so the sel_inc and
    // load_new_PC controls always stay one of the three legal patterns.
    function automatic logic is_redirect(input logic valid, input logic taken,
                                         input logic [1:0] kind);
        logic hit;
        hit = 1'b0;
        if (valid) begin
            case (kind)
                BR_REL:  hit = taken;
                BR_ABS:  hit = 1'b1;
                BR_REG:  hit = 1'b1;
                default: hit = 1'b0;
            endcase
        end
        return hit;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_watchdog.sv
// pc_fetch_watchdog
// Counts consecutive cycles spent waiting for an imem acknowledge and raises
// a sticky timeout flag when the limit is reached.
// Ports:
//   clk        in   core clock
//   reset      in   asynchronous active-high reset
//   waiting_i  in   sequencer is in FETCH/DRAIN without an ack this cycle
//   expire_o   out  limit reached this cycle (combinational pulse)
//   timeout_o  out  sticky flag, cleared only by reset
module pc_fetch_watchdog
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int TMO_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting_i,
    output logic expire_o,
    output logic timeout_o
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign expire_o  = waiting_i && (cnt_q == LIMIT);
    assign timeout_o = timeout_q;

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q | expire_o;
        // Restart counting on any ack / state exit, and after an expiry so the
        // re-issued request gets a fresh window.
        if (!waiting_i || expire_o) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
// Sequencer for the program counter and the instruction-fetch handshake.
// Combines the imem handshake, decode stall requests and branch resolution
// into PC controls plus IF/ID valid/flush strobes.
// Optional feature: define PC_FETCH_CTRL_TIMEOUT_EN to add an imem wait
// watchdog (pc_fetch_watchdog); otherwise imem_timeout is tied low.
// Ports:
//   clk, reset      clock / asynchronous active-high reset
//   imem_ack        instruction word valid on the imem bus
//   stall           hazard unit requests IF hold
//   branch_valid    branch/jump resolved this cycle
//   branch_taken    resolved branch is taken (ignored for jumps)
//   branch_kind     branch_kind_t
//   enable_PC       PC update enable (combinational)
//   sel_inc         1 = PC+4, 0 = relative/absolute target (combinational)
//   load_new_PC     load register target RS1_val (combinational)
//   imem_req        fetch request (state decode)
//   if_valid        IF/ID holds a valid instruction (registered)
//   flush           squash IF/ID (combinational)
//   imem_timeout    sticky watchdog flag
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int DELAY_SLOT     = 0,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int TMO_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       imem_ack,
    input  logic       stall,
    input  logic       branch_valid,
    input  logic       branch_taken,
    input  logic [1:0] branch_kind,
    output logic       enable_PC,
    output logic       sel_inc,
    output logic       load_new_PC,
    output logic       imem_req,
    output logic       if_valid,
    output logic       flush,
    output logic       imem_timeout
);

    // The wait counter must be able to represent the limit.
    if ((TIMEOUT_CYCLES >> TMO_W) != 0) begin : g_cfg_check
        $error("TMO_W too narrow for TIMEOUT_CYCLES");
    end

    state_t state_q, state_d;
    logic   if_valid_q, if_valid_d;
    logic   redirect;
    logic   tmo_expire;

    assign imem_req = (state_q == FETCH);
    assign if_valid = if_valid_q;

`ifdef PC_FETCH_CTRL_TIMEOUT_EN
    logic waiting;

    assign waiting = ((state_q == FETCH) || (state_q == DRAIN)) && !imem_ack;

    pc_fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMO_W          (TMO_W)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .waiting_i (waiting),
        .expire_o  (tmo_expire),
        .timeout_o (imem_timeout)
    );
`else
    assign tmo_expire   = 1'b0;
    assign imem_timeout = 1'b0;
`endif

    // BOOT ignores branch resolution so the PC is never touched there.
    assign redirect = (state_q != BOOT) &&
                      is_redirect(branch_valid, branch_taken, branch_kind);

    always_comb begin
        state_d     = state_q;
        if_valid_d  = if_valid_q;
        enable_PC   = 1'b0;
        sel_inc     = 1'b1;
        load_new_PC = 1'b0;
        flush       = 1'b0;

        case (state_q)
            BOOT: begin
                if_valid_d = 1'b0;
                state_d    = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    if_valid_d = 1'b1;
                    if (stall) begin
                        state_d = HOLD;
                    end else begin
                        enable_PC = 1'b1;
                    end
                end else begin
                    if_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if_valid_d = 1'b1;
                if (!stall) begin
                    enable_PC = 1'b1;
                    state_d   = FETCH;
                end
            end
            DRAIN: begin
                // The ack arriving here belongs to the abandoned fetch.
                if_valid_d = 1'b0;
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // A redirect overrides stall and ack decisions made above. With a
        // delay slot the if_valid value computed above (the slot
        // instruction) is kept.
        if (redirect) begin
            enable_PC = 1'b1;
            if (branch_kind == BR_REG) begin
                load_new_PC = 1'b1;
            end else begin
                sel_inc = 1'b0;
            end
            flush = (DELAY_SLOT == 0);
            if (DELAY_SLOT == 0) begin
                if_valid_d = 1'b0;
            end
            // An unanswered request must be drained before refetching. In
            // DRAIN an ack in the same cycle is the stale one, so it is
            // consumed here instead of waiting for another.
            if ((state_q == FETCH || state_q == DRAIN) && !imem_ack) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end

        // Watchdog expiry abandons the wait and re-issues the request.
        if (tmo_expire) begin
            state_d = FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
        end
    end

endmodule
